// File: rtl/stop_counter_scan.sv
// N-digit BCD up/down counter that halts at a programmable stop value and drives a multiplexed 7-segment display.
// Optional feature macro: LEADING_ZERO_BLANK_EN blanks digits above the most significant non-zero digit.
module stop_counter_scan #(
    parameter int DIGITS   = 2,
    parameter int CLK_HZ   = 100_000_000,
    parameter int COUNT_HZ = 1,
    parameter int SCAN_HZ  = 1_000
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Run,
    input  logic                Up,
    input  logic [4*DIGITS-1:0] Stop,
    output logic [4*DIGITS-1:0] Count,
    output logic                Done,
    output logic [7:0]          Anode,
    output logic [7:0]          Display
);

    localparam int DIV_CNT  = CLK_HZ / COUNT_HZ;
    localparam int DIV_SCAN = CLK_HZ / SCAN_HZ;
    localparam int CW       = $clog2(DIV_CNT);
    localparam int SW       = $clog2(DIV_SCAN);
    localparam int IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV_CNT - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(DIV_SCAN - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [CW-1:0]         cnt_pre_r;
    logic [SW-1:0]         scan_pre_r;
    logic [IW-1:0]         idx_r;
    logic [4*DIGITS-1:0]   count_r;
    logic [7:0]            anode_r;
    logic [7:0]            display_r;
    logic                  count_tick_s;
    logic                  scan_tick_s;
    logic                  done_s;
    logic [4*DIGITS-1:0]   count_next_s;
    logic [3:0]            digit_s;
    logic [7:0]            seg_s;
    logic [7:0]            anode_next_s;
    logic [7:0]            display_next_s;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    // Ripple carry/borrow across digits; all-9s wraps to all-0s and vice versa.
    function automatic logic [4*DIGITS-1:0] bcd_step(input logic [4*DIGITS-1:0] v, input logic up);
        logic [4*DIGITS-1:0] res;
        logic                carry;
        logic [3:0]          nib;
        res   = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            nib = v[4*i +: 4];
            if (!carry) begin
                res[4*i +: 4] = nib;
            end else if (up) begin
                if (nib == 4'd9) begin
                    res[4*i +: 4] = 4'd0;
                end else begin
                    res[4*i +: 4] = nib + 4'd1;
                    carry         = 1'b0;
                end
            end else begin
                if (nib == 4'd0) begin
                    res[4*i +: 4] = 4'd9;
                end else begin
                    res[4*i +: 4] = nib - 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        return res;
    endfunction

    assign count_tick_s = (cnt_pre_r == CNT_LAST);
    assign scan_tick_s  = (scan_pre_r == SCAN_LAST);

    // Stop match; an out-of-range stop nibble can never match.
    always_comb begin
        done_s = (count_r == Stop);
        for (int i = 0; i < DIGITS; i++) begin
            done_s = done_s & (Stop[4*i +: 4] <= 4'd9);
        end
    end

    // Next count value and next display/anode pattern.
    always_comb begin
        count_next_s = bcd_step(count_r, Up);
        digit_s      = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            digit_s = digit_s | ((IW'(i) == idx_r) ? count_r[4*i +: 4] : 4'd0);
        end
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic lead_zero_s;
            lead_zero_s = 1'b1;
            for (int i = 0; i < DIGITS; i++) begin
                lead_zero_s = lead_zero_s & ((IW'(i) < idx_r) | (count_r[4*i +: 4] == 4'd0));
            end
            if (lead_zero_s && (idx_r != {IW{1'b0}})) begin
                seg_s = 8'hFF;
            end else begin
                seg_s = seg7(digit_s);
            end
        end
`else
        seg_s = seg7(digit_s);
`endif
        display_next_s = {seg_s[7] & ~((idx_r == {IW{1'b0}}) & done_s), seg_s[6:0]};
        anode_next_s   = ~(8'h01 << idx_r);
    end

    // Free-running prescalers and scan index.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_pre_r  <= {CW{1'b0}};
            scan_pre_r <= {SW{1'b0}};
            idx_r      <= {IW{1'b0}};
        end else begin
            cnt_pre_r  <= count_tick_s ? {CW{1'b0}} : cnt_pre_r + 1'b1;
            scan_pre_r <= scan_tick_s ? {SW{1'b0}} : scan_pre_r + 1'b1;
            if (scan_tick_s) begin
                idx_r <= (idx_r == IDX_LAST) ? {IW{1'b0}} : idx_r + 1'b1;
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    // BCD counter, frozen while the stop value is matched.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_r <= {(4*DIGITS){1'b0}};
        end else if (count_tick_s && Run && !done_s) begin
            count_r <= count_next_s;
        end else begin
            count_r <= count_r;
        end
    end

    // Registered display pins.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            anode_r   <= 8'hFF;
            display_r <= 8'hFF;
        end else begin
            anode_r   <= anode_next_s;
            display_r <= display_next_s;
        end
    end

    assign Count   = count_r;
    assign Done    = done_s;
    assign Anode   = anode_r;
    assign Display = display_r;

endmodule

// File: tb/tb_stop_counter_scan.sv
// Self-checking bench for stop_counter_scan: cycle scoreboard from a decimal reference model plus scenario checks.
module tb_stop_counter_scan;

    localparam int DIGITS   = 2;
    localparam int CLK_HZ   = 100;
    localparam int COUNT_HZ = 10;
    localparam int SCAN_HZ  = 50;
    localparam int DIV_CNT  = CLK_HZ / COUNT_HZ;
    localparam int DIV_SCAN = CLK_HZ / SCAN_HZ;
    localparam int MOD      = 100;

    logic                Clk = 1'b0;
    logic                Reset;
    logic                Run;
    logic                Up;
    logic [4*DIGITS-1:0] Stop;
    logic [4*DIGITS-1:0] Count;
    logic                Done;
    logic [7:0]          Anode;
    logic [7:0]          Display;

    stop_counter_scan #(
        .DIGITS(DIGITS), .CLK_HZ(CLK_HZ), .COUNT_HZ(COUNT_HZ), .SCAN_HZ(SCAN_HZ)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Up(Up), .Stop(Stop),
        .Count(Count), .Done(Done), .Anode(Anode), .Display(Display)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [4*DIGITS-1:0] count;
        logic                done;
        logic [7:0]          anode;
        logic [7:0]          disp;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    int       m_val, m_cpre, m_spre, m_idx;
    logic [7:0] m_an, m_disp;

    function automatic int pow10(int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [7:0] seg(int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [4*DIGITS-1:0] int2bcd(int v);
        logic [4*DIGITS-1:0] r;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic int stop_val(logic [4*DIGITS-1:0] s);
        int r;
        r = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (s[4*i +: 4] > 4'd9) return -1;
            r = r + int'(s[4*i +: 4]) * pow10(i);
        end
        return r;
    endfunction

    function automatic logic [7:0] exp_disp(int idx, int val, bit dn);
        logic [7:0] d;
        d = seg((val / pow10(idx)) % 10);
`ifdef LEADING_ZERO_BLANK_EN
        if (idx > 0 && val < pow10(idx)) d = 8'hFF;
`endif
        if (idx == 0 && dn) d[7] = 1'b0;
        return d;
    endfunction

    // Advance the model one edge, push its prediction, clock the DUT, pop and compare.
    task automatic step();
        exp_t e, g;
        bit   dn, ctick, stick;
        if (Reset) begin
            m_val = 0; m_cpre = 0; m_spre = 0; m_idx = 0;
            m_an = 8'hFF; m_disp = 8'hFF;
        end else begin
            dn     = (stop_val(Stop) == m_val);
            m_an   = ~(8'h01 << m_idx);
            m_disp = exp_disp(m_idx, m_val, dn);
            ctick  = (m_cpre == DIV_CNT - 1);
            stick  = (m_spre == DIV_SCAN - 1);
            m_cpre = ctick ? 0 : m_cpre + 1;
            m_spre = stick ? 0 : m_spre + 1;
            if (stick) m_idx = (m_idx == DIGITS - 1) ? 0 : m_idx + 1;
            if (ctick && Run && !dn) m_val = Up ? (m_val + 1) % MOD : (m_val + MOD - 1) % MOD;
        end
        e.count = int2bcd(m_val);
        e.done  = (stop_val(Stop) == m_val);
        e.anode = m_an;
        e.disp  = m_disp;
        sb.push_back(e);
        @(posedge Clk);
        @(negedge Clk);
        g = sb.pop_front();
        checks++;
        if (Count !== g.count) begin failures++; $display("FAIL sb_count t=%0t got=%h exp=%h", $time, Count, g.count); end
        checks++;
        if (Done !== g.done) begin failures++; $display("FAIL sb_done t=%0t got=%b exp=%b", $time, Done, g.done); end
        checks++;
        if (Anode !== g.anode) begin failures++; $display("FAIL sb_anode t=%0t got=%h exp=%h", $time, Anode, g.anode); end
        checks++;
        if (Display !== g.disp) begin failures++; $display("FAIL sb_display t=%0t got=%h exp=%h", $time, Display, g.disp); end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        repeat (3) step();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        Stop = 8'hFF; Run = 1'b1; Up = 1'b1;
        do_reset();
        checks++;
        if (Count !== 8'h00 || Done !== 1'b0 || Anode !== 8'hFF || Display !== 8'hFF) begin
            failures++;
            $display("FAIL reset_state got=%h/%b/%h/%h exp=00/0/ff/ff", Count, Done, Anode, Display);
        end
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (Count !== 8'h00) begin n = i; break; end
        end
        checks++;
        if (n != 10 || Count !== 8'h01) begin
            failures++;
            $display("FAIL first_tick got=%0d cycles count=%h exp=10 cycles count=01", n, Count);
        end
    endtask

    task automatic test_count_up();
        logic [7:0] prev;
        bit s0910, s9900, dseen;
        s0910 = 0; s9900 = 0; dseen = 0;
        Stop = 8'hFF; Run = 1'b1; Up = 1'b1;
        prev = Count;
        for (int i = 0; i < 100 * DIV_CNT; i++) begin
            step();
            if (prev == 8'h09 && Count == 8'h10) s0910 = 1;
            if (prev == 8'h99 && Count == 8'h00) s9900 = 1;
            if (Done) dseen = 1;
            prev = Count;
        end
        checks++;
        if (!s0910) begin failures++; $display("FAIL up_09_10 got=0 exp=1"); end
        checks++;
        if (!s9900) begin failures++; $display("FAIL up_99_00 got=0 exp=1"); end
        checks++;
        if (dseen) begin failures++; $display("FAIL up_done_never got=1 exp=0"); end
    endtask

    task automatic test_count_down();
        int n;
        Stop = 8'hFF;
        do_reset();
        Run = 1'b1; Up = 1'b0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (Count !== 8'h00) begin n = i; break; end
        end
        checks++;
        if (n != 10 || Count !== 8'h99) begin failures++; $display("FAIL down_wrap got=%h after %0d exp=99 after 10", Count, n); end
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (Count !== 8'h99) begin n = i; break; end
        end
        checks++;
        if (n != 10 || Count !== 8'h98) begin failures++; $display("FAIL down_next got=%h after %0d exp=98 after 10", Count, n); end
    endtask

    task automatic test_stop();
        bit hit;
        Stop = 8'hFF;
        do_reset();
        Stop = 8'h15; Run = 1'b1; Up = 1'b1;
        repeat (25 * DIV_CNT) step();
        checks++;
        if (Count !== 8'h15 || Done !== 1'b1) begin failures++; $display("FAIL stop_hold got=%h/%b exp=15/1", Count, Done); end
        hit = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (Anode === 8'hFE) begin hit = 1; break; end
        end
        checks++;
        if (!hit || Display !== 8'h12) begin failures++; $display("FAIL stop_dp got=%h/%h exp=fe/12", Anode, Display); end
        Stop = 8'h20;
        hit = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (Count !== 8'h15) begin hit = 1; break; end
        end
        checks++;
        if (!hit || Count !== 8'h16 || Done !== 1'b0) begin failures++; $display("FAIL stop_resume got=%h/%b exp=16/0", Count, Done); end
    endtask

    task automatic test_scan();
        bit hit;
        logic [7:0] hi_exp;
`ifdef LEADING_ZERO_BLANK_EN
        hi_exp = 8'hFF;
`else
        hi_exp = 8'hC0;
`endif
        Stop = 8'hFF;
        do_reset();
        Run = 1'b1; Up = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (Count === 8'h07) break;
        end
        Run = 1'b0;
        hit = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (Anode === 8'hFE) begin hit = 1; break; end
        end
        checks++;
        if (!hit || Display !== 8'hF8) begin failures++; $display("FAIL scan_d0 got=%h/%h exp=fe/f8", Anode, Display); end
        hit = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (Anode === 8'hFD) begin hit = 1; break; end
        end
        checks++;
        if (!hit || Display !== hi_exp) begin failures++; $display("FAIL scan_d1 got=%h/%h exp=fd/%h", Anode, Display, hi_exp); end
    endtask

    task automatic test_reset_mid();
        int n;
        Stop = 8'hFF;
        do_reset();
        Run = 1'b1; Up = 1'b1;
        for (int i = 0; i < 600; i++) begin
            step();
            if (Count === 8'h42) break;
        end
        for (int i = 0; i < DIV_CNT; i++) begin
            if (m_cpre == DIV_CNT - 1) break;
            step();
        end
        checks++;
        if (Count !== 8'h42) begin failures++; $display("FAIL mid_reach got=%h exp=42", Count); end
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        checks++;
        if (Count !== 8'h00 || Anode !== 8'hFF || Display !== 8'hFF) begin
            failures++;
            $display("FAIL mid_reset got=%h/%h/%h exp=00/ff/ff", Count, Anode, Display);
        end
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (Count !== 8'h00) begin n = i; break; end
        end
        checks++;
        if (n != 10) begin failures++; $display("FAIL mid_next_tick got=%0d exp=10", n); end
    endtask

    initial begin
        Reset = 1'b1; Run = 1'b0; Up = 1'b1; Stop = 8'hFF;
        @(negedge Clk);
        test_reset();
        test_count_up();
        test_count_down();
        test_stop();
        test_scan();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stop_counter_scan.md
# stop_counter_scan

Parametrised N-digit BCD up/down counter with a programmable BCD stop value and an integrated time-multiplexed 7-segment scanner, all in a single clock domain with tick enables. The counter runs at a divided rate, halts while its value equals the stop value, and drives the board anode/segment pins directly. It is the generalised successor to the two-digit stop counter in the top-level display path.

## Interface
- DIGITS, 2, number of BCD digits counted and scanned (1..8).
- CLK_HZ, 100_000_000, Clk frequency in Hz.
- COUNT_HZ, 1, count tick rate; DIV_CNT = CLK_HZ/COUNT_HZ (≥2).
- SCAN_HZ, 1_000, digit-advance rate; DIV_SCAN = CLK_HZ/SCAN_HZ (≥2).

- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Run  in  1  1 = count ticks update Count; 0 = hold.
- Up  in  1  1 = increment, 0 = decrement; sampled on each count tick.
- Stop  in  4*DIGITS  BCD stop value, digit 0 (ones) in [3:0].
- Count  out  4*DIGITS  current BCD value.
- Done  out  1  high while Count == Stop.
- Anode  out  8  active-low digit enables; bit i = digit i.
- Display  out  8  active-low segments {dp,g,f,e,d,c,b,a}.

## Operation
- Two free-running prescalers: count prescaler 0..DIV_CNT-1, scan prescaler 0..DIV_SCAN-1; each emits a one-cycle tick when at its terminal value, then wraps to 0. Prescalers run regardless of Run/Done.
- Count update on count tick iff Run=1 and Done=0: BCD ±1 with ripple carry/borrow across digits.
- Wrap: up from all-9s → all-0s; down from all-0s → all-9s.
- Done = combinational compare of registered Count with Stop. Any Stop nibble >9 → never matches, Done=0. While Done=1 ticks are ignored; if Stop changes so Done falls, counting resumes on the next count tick.
- Scanner: index register 0..DIGITS-1 advances on scan tick, wraps to 0.
- Anode: bit[index]=0, all other bits 1; bits ≥DIGITS always 1.
- Display digit codes (dp=1): 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8, 8→80, 9→90. Blank → FF.
- Decimal point (bit 7) driven 0 when index=0 and Done=1; otherwise 1.

## Timing
- Reset values: Count=0, scan index=0, both prescalers=0, Anode=FF, Display=FF. Done follows Count/Stop immediately.
- First count tick occurs DIV_CNT cycles after the cycle Reset deasserts; Count changes on that edge.
- Anode/Display registered: reflect index and Count of the previous cycle (1-cycle latency).
- Reset asserted mid-operation wins over any tick in the same cycle; all state returns to reset values on that edge.
- Run/Up changes between ticks have no effect until the next tick.

## Configuration
- LEADING_ZERO_BLANK_EN defined: any digit above the most significant non-zero digit shows FF; digit 0 is never blanked (Count=0 shows "0").
- Undefined: all DIGITS digits always shown, leading zeros as C0.

## Test plan
(DIGITS=2, CLK_HZ=100, COUNT_HZ=10, SCAN_HZ=50 → DIV_CNT=10, DIV_SCAN=2.)
- Reset held 3 cycles, Stop=8'hFF -> Count=00, Done=0, Anode=FF, Display=FF; first Count change 10 cycles after release.
- Run=1, Up=1, Stop=8'hFF, 100 ticks -> Count passes 09→10 and 99→00; Done never asserts.
- From Count=00, Run=1, Up=0, one tick -> Count=99; next tick 98.
- Stop=8'h15, Up=1 from 00 -> Count holds at 15, Done=1, dp lit on digit 0 scan; Stop→8'h20 -> Count=16 at next tick.
- Count=07, scan two cycles -> Anode FE with Display F8, then Anode FD with Display FF (macro defined) or C0 (undefined).
- Reset pulsed one cycle at Count=42 coinciding with a count tick -> Count=00 next edge, next change 10 cycles later.
